// File: rtl/eth_helper_pkg.sv
// Shared types and sizing helpers for the Ethernet frame-forming blocks.
package eth_helper_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } sched_state_t;

  localparam int FRAME_CNT_W = 32;

  function automatic int GRANT_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: the first requester after the
// previous winner (wrapping) wins.
module rr_arbiter
  import eth_helper_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int GW      = GRANT_W(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [GW-1:0]      last_i,
  output logic [GW-1:0]      winner_o,
  output logic               any_o
);

  int idx;

  // Scan from farthest to nearest so the nearest requester is assigned last.
  always_comb begin
    winner_o = '0;
    idx      = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last_i) + k) % NUM_REQ;
      if (req_i[GW'(idx)]) begin
        winner_o = GW'(idx);
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/frame_source_scheduler.sv
// Round-robin scheduler sharing one frame-former datapath between NUM_SRC
// sample FIFOs, one grant per frame with an enforced idle gap between frames.
module frame_source_scheduler
  import eth_helper_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int GAP_CYCLES = 12
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic                          enable,
  input  logic [NUM_SRC-1:0]            src_empty,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  output logic [NUM_SRC-1:0]            src_rd,
  output logic                          ff_empty,
  output logic [DATA_WIDTH-1:0]         ff_data,
  input  logic                          ff_ready,
  input  logic                          axis_tvalid,
  input  logic                          axis_tready,
  input  logic                          axis_tlast,
  output logic [GRANT_W(NUM_SRC)-1:0]   grant_id,
  output logic                          grant_valid,
  output logic [FRAME_CNT_W-1:0]        frame_count,
  output logic [NUM_SRC-1:0]            underflow,
  output logic [1:0]                    sched_state
);

  localparam int GW      = GRANT_W(NUM_SRC);
  localparam int GAP_EFF = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
  localparam int GAP_W   = $clog2(GAP_EFF + 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_EFF - 1);

  sched_state_t           state_q, state_d;
  logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
  logic [GW-1:0]          grant_id_q, grant_id_d;
  logic [GW-1:0]          last_grant_q, last_grant_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [NUM_SRC-1:0]     underflow_q, underflow_d;

  logic [NUM_SRC-1:0]     src_req;
  logic [GW-1:0]          arb_winner;
  logic                   arb_any;
  logic                   frame_done;
  logic                   busy;

  assign src_req    = ~src_empty;
  assign frame_done = axis_tvalid & axis_tready & axis_tlast;
  assign busy       = (state_q == BUSY);

  rr_arbiter #(
    .NUM_REQ (NUM_SRC)
  ) u_arb (
    .req_i    (src_req),
    .last_i   (last_grant_q),
    .winner_o (arb_winner),
    .any_o    (arb_any)
  );

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q      <= IDLE;
      gap_cnt_q    <= '0;
      grant_id_q   <= '0;
      last_grant_q <= GW'(NUM_SRC - 1);
      frame_cnt_q  <= '0;
      underflow_q  <= '0;
    end else begin
      state_q      <= state_d;
      gap_cnt_q    <= gap_cnt_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      frame_cnt_q  <= frame_cnt_d;
      underflow_q  <= underflow_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    gap_cnt_d    = gap_cnt_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    frame_cnt_d  = frame_cnt_q;
    underflow_d  = underflow_q;
    unique case (state_q)
      IDLE: begin
        if (enable && arb_any) begin
          grant_id_d   = arb_winner;
          last_grant_d = arb_winner;
          state_d      = BUSY;
        end
      end
      BUSY: begin
        // A read request against an empty FIFO keeps the frame going on the stale head word.
        for (int i = 0; i < NUM_SRC; i++) begin
          if ((grant_id_q == GW'(i)) && ff_ready && src_empty[i]) begin
            underflow_d[i] = 1'b1;
          end
        end
        if (frame_done) begin
          frame_cnt_d = frame_cnt_q + 1'b1;
          gap_cnt_d   = GAP_LOAD;
          state_d     = GAP;
        end
      end
      GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ff_data = '0;
    src_rd  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_id_q == GW'(i)) begin
        ff_data   = src_data[i*DATA_WIDTH +: DATA_WIDTH];
        src_rd[i] = busy & ff_ready & ~src_empty[i];
      end
    end
  end

  assign ff_empty    = ~busy;
  assign grant_valid = busy;
  assign grant_id    = grant_id_q;
  assign frame_count = frame_cnt_q;
  assign underflow   = underflow_q;
  assign sched_state = state_q;

endmodule

// File: tb/tb_frame_source_scheduler.sv
// Self-checking bench: timestamp-based reference model of grants, gaps and
// statistics, directed scenarios followed by a randomized soak.
module tb_frame_source_scheduler;

  localparam int NSRC = 4;
  localparam int DW   = 64;
  localparam int GAP  = 12;
  localparam int PKT  = 10;

  logic              ACLK = 1'b0;
  logic              ARESET;
  logic              enable;
  logic [NSRC-1:0]   src_empty;
  logic [NSRC*DW-1:0] src_data;
  logic [NSRC-1:0]   src_rd;
  logic              ff_empty;
  logic [DW-1:0]     ff_data;
  logic              ff_ready;
  logic              axis_tvalid, axis_tready, axis_tlast;
  logic [1:0]        grant_id;
  logic              grant_valid;
  logic [31:0]       frame_count;
  logic [NSRC-1:0]   underflow;
  logic [1:0]        sched_state;

  frame_source_scheduler #(
    .NUM_SRC(NSRC), .DATA_WIDTH(DW), .GAP_CYCLES(GAP)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .enable(enable),
    .src_empty(src_empty), .src_data(src_data), .src_rd(src_rd),
    .ff_empty(ff_empty), .ff_data(ff_data), .ff_ready(ff_ready),
    .axis_tvalid(axis_tvalid), .axis_tready(axis_tready), .axis_tlast(axis_tlast),
    .grant_id(grant_id), .grant_valid(grant_valid), .frame_count(frame_count),
    .underflow(underflow), .sched_state(sched_state)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;
  int edges  = 0;
  bit modelValid = 0;

  // Reference model: busy flag, granted source, and the edge at which the last frame ended.
  bit          mBusy  = 0;
  int          mGrant = 0;
  int          mLast  = NSRC - 1;
  int          mTlast = -1000;
  logic [31:0] mFrames = '0;
  logic [NSRC-1:0] mUnder = '0;
  int          beat = 0;

  bit          measureGaps = 0;
  bit          gapArmed = 0;
  int          emptyRun = 0;
  bit          prevGv = 0;
  bit          gvSeen = 0;
  logic [NSRC-1:0] rdSeen = '0;
  int          grantLog[$];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, edges);
    end
  endtask

  function automatic int pickNext(input logic [NSRC-1:0] empt, input int last);
    for (int k = 1; k <= NSRC; k++) begin
      int c;
      c = (last + k) % NSRC;
      if (!empt[c]) return c;
    end
    return -1;
  endfunction

  task automatic checkAll();
    int expState;
    logic [NSRC-1:0] expRd;
    if (!modelValid) return;
    expState = mBusy ? 1 : ((edges < mTlast + GAP) ? 2 : 0);
    expRd = '0;
    if (mBusy && ff_ready && !src_empty[mGrant]) expRd[mGrant] = 1'b1;
    checkOutput("sched_state", sched_state, expState);
    checkOutput("grant_valid", grant_valid, mBusy);
    checkOutput("ff_empty", ff_empty, !mBusy);
    checkOutput("grant_id", grant_id, mGrant);
    checkOutput("frame_count", frame_count, mFrames);
    checkOutput("underflow", underflow, mUnder);
    checkOutput("src_rd", src_rd, expRd);
    checkOutput("ff_data", ff_data, src_data[mGrant*DW +: DW]);
  endtask

  task automatic modelUpdate();
    int c;
    if (ARESET) begin
      mBusy = 0; mGrant = 0; mLast = NSRC - 1; mTlast = -1000;
      mFrames = '0; mUnder = '0; beat = 0; modelValid = 1;
    end else if (mBusy) begin
      if (ff_ready && src_empty[mGrant]) mUnder[mGrant] = 1'b1;
      if (axis_tvalid && axis_tready) beat = axis_tlast ? 0 : beat + 1;
      if (axis_tvalid && axis_tready && axis_tlast) begin
        mFrames = mFrames + 1;
        mBusy   = 0;
        mTlast  = edges + 1;
        if (measureGaps) begin
          gapArmed = 1;
          emptyRun = 0;
        end
      end
    end else if (!(edges < mTlast + GAP) && enable) begin
      c = pickNext(src_empty, mLast);
      if (c >= 0) begin
        mBusy = 1; mGrant = c; mLast = c; beat = 0;
      end
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit en, input logic [NSRC-1:0] empt,
                               input bit ffr, input bit randomHs);
    ARESET    = rst;
    enable    = en;
    src_empty = empt;
    ff_ready  = ffr;
    for (int i = 0; i < NSRC*DW/32; i++) src_data[i*32 +: 32] = $urandom;
    if (randomHs) begin
      axis_tvalid = ($urandom % 4) != 0;
      axis_tready = ($urandom % 4) != 0;
      axis_tlast  = (beat >= PKT - 1) || (($urandom % 16) == 0);
    end else begin
      axis_tvalid = mBusy;
      axis_tready = 1'b1;
      axis_tlast  = mBusy && (beat == PKT - 1);
    end
  endtask

  task automatic tickCycle();
    #1;
    checkAll();
    if (gapArmed) begin
      if (ff_empty) emptyRun++;
      else begin
        checkOutput("gap_len", emptyRun, GAP + 1);
        gapArmed = 0;
      end
    end
    if (grant_valid && !prevGv) grantLog.push_back(int'(grant_id));
    prevGv = grant_valid;
    gvSeen = gvSeen | grant_valid;
    rdSeen = rdSeen | src_rd;
    modelUpdate();
    @(posedge ACLK);
    edges++;
    @(negedge ACLK);
  endtask

  initial begin
    int f0;
    int rrExp[5] = '{0, 1, 2, 3, 0};
    int skExp[3] = '{1, 3, 1};
    ARESET = 1; enable = 1; src_empty = '0; src_data = '0; ff_ready = 1;
    axis_tvalid = 0; axis_tready = 0; axis_tlast = 0;
    @(negedge ACLK);

    // Reset held three cycles with every source non-empty.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 4'b0000, 1, 0);
      tickCycle();
      checkOutput("rst_ff_empty", ff_empty, 1);
      checkOutput("rst_src_rd", src_rd, 0);
      checkOutput("rst_frame_count", frame_count, 0);
    end
    grantLog.delete();
    applyStimulus(0, 1, 4'b0000, 1, 0);
    tickCycle();
    checkOutput("first_grant_valid", grant_valid, 1);
    checkOutput("first_grant_id", grant_id, 0);

    // Round-robin across all four sources, with gap length measured.
    measureGaps = 1;
    for (int n = 0; n < 600 && mFrames != 5; n++) begin
      applyStimulus(0, 1, 4'b0000, 1, 0);
      tickCycle();
    end
    if (mFrames != 5) checkOutput("timeout_rr", 0, 1);
    measureGaps = 0;
    checkOutput("rr_frames", frame_count, 5);
    checkOutput("rr_grant_count", grantLog.size(), 5);
    for (int i = 0; i < 5 && i < grantLog.size(); i++) checkOutput("rr_grant_seq", grantLog[i], rrExp[i]);

    // Only sources 1 and 3 have data.
    grantLog.delete();
    rdSeen = '0;
    for (int n = 0; n < 600 && mFrames != 8; n++) begin
      applyStimulus(0, 1, 4'b0101, 1, 0);
      tickCycle();
    end
    if (mFrames != 8) checkOutput("timeout_skip", 0, 1);
    checkOutput("skip_grant_count", grantLog.size(), 3);
    for (int i = 0; i < 3 && i < grantLog.size(); i++) checkOutput("skip_grant_seq", grantLog[i], skExp[i]);
    checkOutput("skip_rd0", rdSeen[0], 0);
    checkOutput("skip_rd2", rdSeen[2], 0);

    // Source 2 runs dry mid-frame while the frame former keeps asking.
    for (int n = 0; n < 100 && !(mBusy && mGrant == 2); n++) begin
      applyStimulus(0, 1, 4'b1011, 1, 0);
      tickCycle();
    end
    if (!(mBusy && mGrant == 2)) checkOutput("timeout_uflow_grant", 0, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 4'b1011, 1, 0);
      tickCycle();
    end
    applyStimulus(0, 1, 4'b1111, 1, 0);
    #1 checkOutput("uflow_no_pop", src_rd, 0);
    tickCycle();
    checkOutput("uflow_flag", underflow, 4'b0100);
    for (int n = 0; n < 100 && mFrames != 9; n++) begin
      applyStimulus(0, 1, 4'b1011, 1, 0);
      tickCycle();
    end
    checkOutput("uflow_frame_done", frame_count, 9);

    // Reset pulse in the middle of a frame.
    for (int n = 0; n < 100 && !mBusy; n++) begin
      applyStimulus(0, 1, 4'b0000, 1, 0);
      tickCycle();
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 4'b0000, 1, 0);
      tickCycle();
    end
    applyStimulus(1, 1, 4'b0000, 1, 0);
    tickCycle();
    checkOutput("midrst_state", sched_state, 0);
    checkOutput("midrst_gv", grant_valid, 0);
    checkOutput("midrst_frames", frame_count, 0);
    checkOutput("midrst_underflow", underflow, 0);

    // Disable during a frame: it finishes, then no new grant.
    for (int n = 0; n < 100 && !mBusy; n++) begin
      applyStimulus(0, 1, 4'b0000, 1, 0);
      tickCycle();
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 4'b0000, 1, 0);
      tickCycle();
    end
    f0 = int'(mFrames);
    for (int n = 0; n < 100 && int'(mFrames) == f0; n++) begin
      applyStimulus(0, 0, 4'b0000, 1, 0);
      tickCycle();
    end
    checkOutput("dis_frame_done", frame_count, f0 + 1);
    gvSeen = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(0, 0, 4'b0000, 1, 0);
      tickCycle();
    end
    checkOutput("dis_no_grant", gvSeen, 0);

    // Randomized soak with occasional resets and spurious tlast.
    for (int n = 0; n < 3000; n++) begin
      applyStimulus(($urandom % 300) == 0, ($urandom % 8) != 0, NSRC'($urandom),
                    $urandom % 2, 1);
      tickCycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
